// File: rtl/bnn_pkg.sv
// Constants and types shared by the window generator and the convolution engine.
package bnn_pkg;

  localparam int K      = 5;
  localparam int PIX_W  = 8;
  localparam int NI_L1  = 28;
  localparam int NI_L2  = 12;
  localparam int NI_MAX = 28;
  localparam int TAPS_W = K * PIX_W;
  localparam int CNT_W  = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_t;

  // Map width selected by the layer flag (0: layer 1, 1: layer 2).
  function automatic logic [CNT_W-1:0] ni_sel(input logic layer2);
    return layer2 ? CNT_W'(NI_L2) : CNT_W'(NI_L1);
  endfunction

endpackage

// File: rtl/line_mem.sv
// Four-line column-shift memory. Reads are combinational on the current
// column address; a write shifts that column up one line and stores the new
// pixel in the newest line, so the read sees pre-write contents.
module line_mem #(
  parameter int DEPTH = 28,
  parameter int W     = 8,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_l0,
  output logic [W-1:0]  o_l1,
  output logic [W-1:0]  o_l2,
  output logic [W-1:0]  o_l3
);

  logic [W-1:0] r_l0 [DEPTH];
  logic [W-1:0] r_l1 [DEPTH];
  logic [W-1:0] r_l2 [DEPTH];
  logic [W-1:0] r_l3 [DEPTH];

  assign o_l0 = r_l0[i_addr];
  assign o_l1 = r_l1[i_addr];
  assign o_l2 = r_l2[i_addr];
  assign o_l3 = r_l3[i_addr];

  // Column shift on write: oldest line drops out, incoming pixel enters newest.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_l0[i_addr] <= r_l1[i_addr];
      r_l1[i_addr] <= r_l2[i_addr];
      r_l2[i_addr] <= r_l3[i_addr];
      r_l3[i_addr] <= i_din;
    end
  end

endmodule

// File: rtl/line_buffer5.sv
// Window-column generator: buffers four rows of a raster pixel stream and
// emits one five-pixel column per accepted pixel, with window-valid flags.
module line_buffer5 #(
  parameter int K      = bnn_pkg::K,
  parameter int NI_MAX = bnn_pkg::NI_MAX
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         state,
  input  logic [bnn_pkg::PIX_W-1:0]    din,
  input  logic                         din_valid,
  output logic [K*bnn_pkg::PIX_W-1:0]  taps,
  output logic                         taps_valid,
  output logic                         win_valid,
  output logic                         busy,
  output logic                         done
);

  import bnn_pkg::*;

  localparam int TW = K * PIX_W;

  fsm_t             r_fsm;
  fsm_t             w_fsm_nxt;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_ni;
  logic             w_accept;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_frame_last;
  logic [PIX_W-1:0] w_l0;
  logic [PIX_W-1:0] w_l1;
  logic [PIX_W-1:0] w_l2;
  logic [PIX_W-1:0] w_l3;

  // start overrides a same-cycle pixel, which is discarded.
  assign w_accept     = din_valid && (r_fsm == ST_RUN) && !start;
  assign w_col_last   = (r_col == (r_ni - 5'd1));
  assign w_row_last   = (r_row == (r_ni - 5'd1));
  assign w_frame_last = w_col_last && w_row_last;

  line_mem #(
    .DEPTH (NI_MAX),
    .W     (PIX_W),
    .AW    (CNT_W)
  ) u_line_mem (
    .clk    (clk),
    .i_we   (w_accept),
    .i_addr (r_col),
    .i_din  (din),
    .o_l0   (w_l0),
    .o_l1   (w_l1),
    .o_l2   (w_l2),
    .o_l3   (w_l3)
  );

  // Frame FSM next state: start (re)enters RUN, the last pixel returns to IDLE.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_IDLE: begin
        if (start) w_fsm_nxt = ST_RUN;
        else       w_fsm_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (start)                         w_fsm_nxt = ST_RUN;
        else if (w_accept && w_frame_last) w_fsm_nxt = ST_IDLE;
        else                               w_fsm_nxt = ST_RUN;
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  // Frame FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= ST_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  // Raster counters and latched map width; start clears and relatches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= 5'd0;
      r_row <= 5'd0;
      r_ni  <= ni_sel(1'b0);
    end else if (start) begin
      r_col <= 5'd0;
      r_row <= 5'd0;
      r_ni  <= ni_sel(state);
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= 5'd0;
        r_row <= w_row_last ? 5'd0 : r_row + 5'd1;
      end else begin
        r_col <= r_col + 5'd1;
      end
    end
  end

  // Registered outputs: column, validity flags, busy and end-of-frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps       <= {TW{1'b0}};
      taps_valid <= 1'b0;
      win_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (w_accept) taps <= {w_l0, w_l1, w_l2, w_l3, din};
      taps_valid <= w_accept && (r_row >= 5'd4);
      win_valid  <= w_accept && (r_row >= 5'd4) && (r_col >= 5'd4);
      busy       <= (w_fsm_nxt == ST_RUN);
      done       <= w_accept && w_frame_last;
    end
  end

endmodule

// File: tb/tb_line_buffer5.sv
// Self-checking bench for line_buffer5: directed table plus frame sequences.
module tb_line_buffer5;

  logic        clk;
  logic        rst;
  logic        start;
  logic        state;
  logic [7:0]  din;
  logic        din_valid;
  logic [39:0] taps;
  logic        taps_valid;
  logic        win_valid;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  line_buffer5 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .state      (state),
    .din        (din),
    .din_valid  (din_valid),
    .taps       (taps),
    .taps_valid (taps_valid),
    .win_valid  (win_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        state;
    logic [7:0]  din;
    logic        dv;
    logic        e_tv;
    logic        e_wv;
    logic        e_busy;
    logic        e_done;
    logic [39:0] e_taps;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic st, input logic [7:0] d, input logic dv);
    start     = s;
    state     = st;
    din       = d;
    din_valid = dv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix(input int idx);
    return 8'(idx % 128);
  endfunction

  function automatic logic [39:0] model_taps(input int r, input int c, input int ni);
    logic [39:0] t;
    t = 40'd0;
    for (int k = 0; k < 5; k++) t[39-8*k -: 8] = pix((r - 4 + k) * ni + c);
    return t;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_taps"}, 64'(taps), 64'd0);
    chk({tag, "_tv"}, 64'(taps_valid), 64'd0);
    chk({tag, "_wv"}, 64'(win_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic do_start(input logic st);
    drive(1'b1, st, 8'h00, 1'b0);
    tick();
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_tv", 64'(taps_valid), 64'd0);
    chk("start_done", 64'(done), 64'd0);
  endtask

  // Feeds npix raster pixels of an ni x ni frame, optionally inserting idle
  // cycles before pixel gap_at, and checks every output cycle.
  task automatic run_pixels(input int ni, input int npix, input int gap_at, input int gap_len,
                            output int wins, output int dones);
    logic [39:0] exp_prev;
    int r;
    int c;
    logic last;
    logic e_tv;
    logic e_wv;
    wins     = 0;
    dones    = 0;
    exp_prev = 40'd0;
    for (int p = 0; p < npix; p++) begin
      r = p / ni;
      c = p % ni;
      if (p == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          drive(1'b0, 1'b0, 8'hA5, 1'b0);
          tick();
          chk("gap_tv", 64'(taps_valid), 64'd0);
          chk("gap_wv", 64'(win_valid), 64'd0);
          chk("gap_taps_held", 64'(taps), 64'(exp_prev));
          chk("gap_busy", 64'(busy), 64'd1);
        end
      end
      drive(1'b0, 1'b0, pix(p), 1'b1);
      tick();
      last = (p == ni * ni - 1);
      e_tv = (r >= 4);
      e_wv = (r >= 4) && (c >= 4);
      chk("px_tv", 64'(taps_valid), 64'(e_tv));
      chk("px_wv", 64'(win_valid), 64'(e_wv));
      chk("px_done", 64'(done), 64'(last));
      chk("px_busy", 64'(busy), 64'(!last));
      if (e_tv) begin
        exp_prev = model_taps(r, c, ni);
        chk("px_taps", 64'(taps), 64'(exp_prev));
      end
      if (ni == 28 && r == 4 && c == 4)
        chk("first_window_taps", 64'(taps), 64'h04_20_3C_58_74);
      if (win_valid) wins++;
      if (done) dones++;
    end
  endtask

  int wins;
  int dones;

  initial begin
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    check_zero("post_reset");

    // Idle pixels ignored, then start+pixel in same cycle (pixel dropped).
    vecs[0] = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40'd0};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 40'd0};
    vecs[2] = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 40'd0};
    vecs[3] = '{1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 40'd0};
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i].start, vecs[i].state, vecs[i].din, vecs[i].dv);
      tick();
      chk("vec_tv", 64'(taps_valid), 64'(vecs[i].e_tv));
      chk("vec_wv", 64'(win_valid), 64'(vecs[i].e_wv));
      chk("vec_busy", 64'(busy), 64'(vecs[i].e_busy));
      chk("vec_done", 64'(done), 64'(vecs[i].e_done));
      chk("vec_taps", 64'(taps), 64'(vecs[i].e_taps));
    end

    // Ni = 12 frame; first accepted pixel must be (0,0).
    run_pixels(12, 144, -1, 0, wins, dones);
    chk("ni12_windows", 64'(wins), 64'd64);
    chk("ni12_dones", 64'(dones), 64'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    chk("ni12_after_done", 64'(done), 64'd0);
    chk("ni12_after_busy", 64'(busy), 64'd0);

    // Ni = 28 frame with a 3-cycle gap in row 5.
    do_start(1'b0);
    run_pixels(28, 784, 5 * 28 + 10, 3, wins, dones);
    chk("ni28_windows", 64'(wins), 64'd576);
    chk("ni28_dones", 64'(dones), 64'd1);

    // Abort at pixel 300 with a restart into layer 2.
    do_start(1'b0);
    run_pixels(28, 300, -1, 0, wins, dones);
    chk("abort_first_dones", 64'(dones), 64'd0);
    drive(1'b1, 1'b1, 8'h7F, 1'b1);
    tick();
    chk("abort_tv", 64'(taps_valid), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_busy", 64'(busy), 64'd1);
    run_pixels(12, 144, -1, 0, wins, dones);
    chk("abort_windows", 64'(wins), 64'd64);
    chk("abort_dones", 64'(dones), 64'd1);

    // Reset in the middle of a frame with flags active.
    do_start(1'b0);
    run_pixels(28, 150, -1, 0, wins, dones);
    chk("pre_rst_tv", 64'(taps_valid), 64'd1);
    drive(1'b0, 1'b0, 8'h33, 1'b1);
    rst = 1'b1;
    #1;
    check_zero("in_reset");
    tick();
    check_zero("in_reset2");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 8'(i + 1), 1'b1);
      tick();
      check_zero("dv_no_start");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
